pagerank_scheduler: RTL and testbench
=====================================

# pagerank_scheduler

Controller that sequences NUM_PARTITIONS pagerank scatter units across multiple PageRank iterations. It time-shares the single gather input port by granting exactly one scatter unit per cycle. Grants rotate round-robin with a burst cap. The block drains gather between iterations, then broadcasts the next-iteration pulse. It sits between the top-level host control and the scatter array, and drives each unit's enable and the select of the external scatter-to-gather mux.

## Interface
Parameters:
- NUM_PARTITIONS, 4, number of scatter units (≥2)
- MAX_BURST, 8, maximum consecutive output cycles a unit keeps the grant
- GW, $clog2(NUM_PARTITIONS), grant index width (derived, not overridden)

Ports:
- clock  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- num_iterations  in  32  iterations to run; latched on accepted start
- part_complete  in  NUM_PARTITIONS  per-unit operation_complete
- part_output_ready  in  NUM_PARTITIONS  per-unit output_ready
- gather_idle  in  1  gather queue empty and no update in flight
- part_enable  out  NUM_PARTITIONS  per-unit pagerank_enable
- next_iteration  out  1  broadcast nextIteration pulse
- grant_id  out  GW  index of the granted unit; selects the gather mux
- iteration  out  32  completed-iteration count
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when the run finishes

## Operation
States:
- IDLE: start=1 latches num_iterations, clears iteration, sets grant=0, burst=0. If num_iterations==0, go to FINISH; otherwise go to RUN.
- RUN:
  - part_enable is one-hot at grant_id.
  - Each cycle, evaluate the granted unit g:
    - If part_complete[g] is 1, or part_output_ready[g] is 0, or burst reaches MAX_BURST-1 while part_output_ready[g] is 1, rotate.
    - Otherwise, if part_output_ready[g] is 1, burst increments.
  - Rotate: grant becomes the next index after g, modulo N, whose part_complete is 0. Burst resets to 0.
  - If all part_complete bits are 1, go to DRAIN. This check has priority over rotation.
- DRAIN: part_enable=0. When gather_idle=1, go to SYNC.
- SYNC: one cycle with part_enable all 1 and next_iteration=1. iteration is incremented.
  - If the new iteration == num_iterations, go to FINISH.
  - Otherwise go to RUN with grant=0 and burst=0.
- FINISH: done=1 for one cycle, then go to IDLE.

Rules:
- start is ignored while busy.
- Partitions with part_complete=1 are skipped by rotation but stay frozen (enable low) until SYNC.
- If no incomplete unit exists at rotation time, the all-complete check wins and the block goes to DRAIN.
- iteration is 32-bit and never wraps within a run, because the latched num_iterations bounds it.

## Timing
- All state is registered. Outputs are a Moore decode of state, grant and burst; inputs do not reach outputs combinationally.
- Reset values: state=IDLE; part_enable=0; next_iteration=0; grant_id=0; iteration=0; busy=0; done=0.
- Reset asserted mid-run returns the block to IDLE immediately. No done pulse is produced.
- start in IDLE at edge k: busy=1 from k+1. With num_iterations==0, done=1 during cycle k+1 only.
- A rotation decided at edge k moves part_enable to the new unit in cycle k+1. This gives exactly one dead-or-handoff cycle; no two units are ever enabled in RUN.
- A unit streaming continuously keeps the grant for exactly MAX_BURST cycles.
- gather_idle already 1 on DRAIN entry: DRAIN lasts 1 cycle.
- next_iteration is high for exactly 1 cycle per iteration and always coincides with all enables high.

## Structure
- Shared package pagerank_pkg holds:
  - typedef enum logic [2:0] {IDLE, RUN, DRAIN, SYNC, FINISH} sched_state_t
  - the default MAX_BURST constant
- Sub-module rr_next_sel (combinational, parameterised N): computes the next incomplete index after g from the part_complete mask.
- Burst and iteration counters are inline.

## Test plan
- Reset: hold reset_n=0 mid-RUN -> all outputs 0 and state IDLE on the same edge; no done pulse.
- num_iterations=0, start pulse -> busy high 1 cycle; done=1 one cycle after start; part_enable never asserted.
- N=4, MAX_BURST=8, unit 0 holds output_ready=1 for 20 cycles -> grant_id=0 for exactly 8 cycles, then 1, then 2, then 3, then 0; part_enable is always one-hot.
- Units 1 and 2 complete early -> rotation sequence is 0,3,0,3 only; when all four complete, DRAIN is entered next cycle and part_enable=0.
- DRAIN with gather_idle held low 5 cycles -> exactly 5 DRAIN cycles; then one SYNC cycle with next_iteration=1 and part_enable=4'b1111; iteration advances from 0 to 1.
- num_iterations=3, full run -> exactly 3 next_iteration pulses; iteration reads 3 at done; start asserted while busy has no effect.

Source files
------------

// File: rtl/pagerank_pkg.sv
// Shared types and defaults for the PageRank scatter scheduler.
package pagerank_pkg;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, SYNC, FINISH} sched_state_t;

    localparam int DEFAULT_MAX_BURST = 8;

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin pick of the first incomplete unit strictly after cur, wrapping
// around so cur itself is the last candidate.
module rr_next_sel #(
    parameter int N  = 4,
    parameter int GW = $clog2(N)
) (
    input  logic [GW-1:0] cur,
    input  logic [N-1:0]  complete_mask,
    output logic [GW-1:0] next_idx,
    output logic          found
);

    logic [GW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest incomplete unit wins.
    always_comb begin
        next_idx = cur;
        found    = 1'b0;
        cand     = cur;
        for (int off = N; off >= 1; off--) begin
            cand = GW'((int'(cur) + off) % N);
            if (!complete_mask[cand]) begin
                next_idx = cand;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pagerank_scheduler.sv
// Sequences the scatter units across PageRank iterations: round-robin grant of
// the shared gather port with a burst cap, drain, then a broadcast sync pulse.
module pagerank_scheduler
    import pagerank_pkg::*;
#(
    parameter int NUM_PARTITIONS = 4,
    parameter int MAX_BURST      = DEFAULT_MAX_BURST,
    parameter int GW             = $clog2(NUM_PARTITIONS)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [31:0]               num_iterations,
    input  logic [NUM_PARTITIONS-1:0] part_complete,
    input  logic [NUM_PARTITIONS-1:0] part_output_ready,
    input  logic                      gather_idle,
    output logic [NUM_PARTITIONS-1:0] part_enable,
    output logic                      next_iteration,
    output logic [GW-1:0]             grant_id,
    output logic [31:0]               iteration,
    output logic                      busy,
    output logic                      done
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    sched_state_t  state;
    logic [GW-1:0] grant;
    logic [BW-1:0] burst;
    logic [31:0]   iter_cnt;
    logic [31:0]   iter_target;

    logic [GW-1:0] next_grant;
    logic          next_found;
    logic          all_complete;
    logic          rotate;
    logic [31:0]   iter_inc;

    rr_next_sel #(
        .N  (NUM_PARTITIONS),
        .GW (GW)
    ) u_next_sel (
        .cur           (grant),
        .complete_mask (part_complete),
        .next_idx      (next_grant),
        .found         (next_found)
    );

    assign all_complete = &part_complete;
    // A unit gives up the port when finished, stalled, or at its burst limit.
    assign rotate       = part_complete[grant] || !part_output_ready[grant] ||
                          (burst == BURST_LAST);
    assign iter_inc     = iter_cnt + 32'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= '0;
            burst       <= '0;
            iter_cnt    <= '0;
            iter_target <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        iter_target <= num_iterations;
                        iter_cnt    <= '0;
                        grant       <= '0;
                        burst       <= '0;
                        state       <= (num_iterations == 32'd0) ? FINISH : RUN;
                    end
                end
                RUN: begin
                    if (all_complete) begin
                        burst <= '0;
                        state <= DRAIN;
                    end else if (rotate) begin
                        if (next_found) grant <= next_grant;
                        burst <= '0;
                    end else begin
                        burst <= burst + 1'b1;
                    end
                end
                DRAIN: begin
                    if (gather_idle) state <= SYNC;
                end
                SYNC: begin
                    iter_cnt <= iter_inc;
                    grant    <= '0;
                    burst    <= '0;
                    state    <= (iter_inc == iter_target) ? FINISH : RUN;
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Moore decode: outputs depend only on registered state.
    always_comb begin
        part_enable = '0;
        if (state == RUN) begin
            part_enable[grant] = 1'b1;
        end else if (state == SYNC) begin
            part_enable = '1;
        end
    end

    assign next_iteration = (state == SYNC);
    assign grant_id       = grant;
    assign iteration      = iter_cnt;
    assign busy           = (state != IDLE);
    assign done           = (state == FINISH);

endmodule

// File: tb/tb_pagerank_scheduler.sv
// Scoreboard bench: stimulus queues expected grant/drain/sync/done events, a
// negedge monitor collapses DUT activity into events and compares them.
module tb_pagerank_scheduler;

    localparam int N  = 4;
    localparam int MB = 8;
    localparam int GW = $clog2(N);

    localparam int K_GRANT = 0;
    localparam int K_DRAIN = 1;
    localparam int K_SYNC  = 2;
    localparam int K_DONE  = 3;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   num_iterations = '0;
    logic [N-1:0]  part_complete = '0;
    logic [N-1:0]  part_output_ready = '0;
    logic          gather_idle = 1'b1;
    logic [N-1:0]  part_enable;
    logic          next_iteration;
    logic [GW-1:0] grant_id;
    logic [31:0]   iteration;
    logic          busy;
    logic          done;

    pagerank_scheduler #(
        .NUM_PARTITIONS (N),
        .MAX_BURST      (MB)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .num_iterations    (num_iterations),
        .part_complete     (part_complete),
        .part_output_ready (part_output_ready),
        .gather_idle       (gather_idle),
        .part_enable       (part_enable),
        .next_iteration    (next_iteration),
        .grant_id          (grant_id),
        .iteration         (iteration),
        .busy              (busy),
        .done              (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int kind;
        int id;
        int len;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    bit  mon_en = 1'b0;
    int  seg_kind = -1;
    int  seg_id = 0;
    int  seg_len = 0;
    int  sync_cnt = 0;

    function automatic string kname(input int k);
        case (k)
            K_GRANT: return "grant";
            K_DRAIN: return "drain";
            K_SYNC:  return "sync";
            default: return "done";
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push(input int k, input int id, input int len);
        ev_t e;
        e.kind = k;
        e.id   = id;
        e.len  = len;
        exp_q.push_back(e);
    endfunction

    task automatic emit(input int k, input int id, input int len);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL event: got %s id=%0d len=%0d, none expected (t=%0t)",
                     kname(k), id, len, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.id != id || e.len != len) begin
                fails++;
                $display("FAIL event: got %s id=%0d len=%0d expected %s id=%0d len=%0d (t=%0t)",
                         kname(k), id, len, kname(e.kind), e.id, e.len, $time);
            end
        end
    endtask

    task automatic flush();
        if (seg_kind >= 0) emit(seg_kind, seg_id, seg_len);
        seg_kind = -1;
    endtask

    // Monitor: grant and drain cycles are merged into run-length segments.
    always @(negedge clock) begin
        if (!reset_n || !mon_en) begin
            seg_kind = -1;
        end else if (done) begin
            flush();
            emit(K_DONE, int'(iteration), 0);
        end else if (next_iteration) begin
            flush();
            sync_cnt++;
            emit(K_SYNC, int'(part_enable), 0);
        end else if (busy) begin
            int k;
            int id;
            k  = (part_enable == '0) ? K_DRAIN : K_GRANT;
            id = (k == K_GRANT) ? int'(grant_id) : 0;
            if (k == K_GRANT)
                chk("onehot_enable", 32'(part_enable), 32'd1 << grant_id);
            if (seg_kind == k && seg_id == id) begin
                seg_len++;
            end else begin
                flush();
                seg_kind = k;
                seg_id   = id;
                seg_len  = 1;
            end
        end else begin
            flush();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [31:0] n);
        num_iterations = n;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_sig(input string name, input bit want_done, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clock);
            if (want_done ? done : next_iteration) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout after %0d cycles", name, bound);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_part_enable"}, 32'(part_enable), 32'd0);
        chk({tag, "_next_iteration"}, 32'(next_iteration), 32'd0);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        chk({tag, "_iteration"}, iteration, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, then an asynchronous reset in the middle of a run.
        tick(2);
        chk_idle_outputs("reset");
        reset_n = 1'b1;
        tick(1);
        chk("post_reset_busy", 32'(busy), 32'd0);
        do_start(2);
        tick(4);
        @(negedge clock);
        chk("midrun_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk_idle_outputs("async_reset");
        repeat (3) begin
            @(negedge clock);
            chk("no_done_in_reset", 32'(done), 32'd0);
        end
        @(posedge clock);
        #1 reset_n = 1'b1;
        tick(2);
        mon_en = 1'b1;

        // Zero iterations: straight to a one-cycle done.
        push(K_DONE, 0, 0);
        do_start(0);
        @(negedge clock);
        chk("zero_iter_done", 32'(done), 32'd1);
        chk("zero_iter_busy", 32'(busy), 32'd1);
        chk("zero_iter_enable", 32'(part_enable), 32'd0);
        tick(1);
        @(negedge clock);
        chk("zero_iter_done_gone", 32'(done), 32'd0);
        chk("zero_iter_busy_gone", 32'(busy), 32'd0);
        tick(2);

        // Unit 0 streams: 8-cycle burst cap, idle units pass in one cycle each.
        gather_idle = 1'b1;
        part_output_ready = 4'b0001;
        push(K_GRANT, 0, 8); push(K_GRANT, 1, 1); push(K_GRANT, 2, 1); push(K_GRANT, 3, 1);
        push(K_GRANT, 0, 8); push(K_GRANT, 1, 1);
        push(K_DRAIN, 0, 1); push(K_SYNC, 4'hF, 0); push(K_DONE, 1, 0);
        do_start(1);
        tick(19);
        part_complete = 4'hF;
        part_output_ready = '0;
        wait_sig("burst_done", 1'b1, 50);
        tick(1);
        part_complete = '0;
        tick(2);

        // Units 1 and 2 already complete; DRAIN held 5 cycles by gather_idle.
        part_complete = 4'b0110;
        gather_idle = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(K_GRANT, 0, 1);
            push(K_GRANT, 3, 1);
        end
        push(K_DRAIN, 0, 5); push(K_SYNC, 4'hF, 0); push(K_DONE, 1, 0);
        do_start(1);
        tick(5);
        part_complete = 4'hF;
        tick(5);
        gather_idle = 1'b1;
        wait_sig("skip_done", 1'b1, 50);
        chk("skip_iteration", iteration, 32'd1);
        tick(1);
        part_complete = '0;
        tick(2);

        // Three full iterations; a start pulse while busy must be ignored.
        sync_cnt = 0;
        for (int it = 0; it < 3; it++) begin
            for (int u = 0; u < N; u++) push(K_GRANT, u, 1);
            push(K_DRAIN, 0, 1);
            push(K_SYNC, 4'hF, 0);
        end
        push(K_DONE, 3, 0);
        do_start(3);
        for (int it = 0; it < 3; it++) begin
            if (it == 1) begin
                num_iterations = 32'd0;
                start = 1'b1;
                tick(1);
                start = 1'b0;
                tick(2);
            end else begin
                tick(3);
            end
            part_complete = 4'hF;
            wait_sig("multi_sync", 1'b0, 20);
            part_complete = '0;
            tick(1);
        end
        wait_sig("multi_done", 1'b1, 10);
        chk("multi_iteration", iteration, 32'd3);
        tick(3);
        chk("multi_sync_count", 32'(sync_cnt), 32'd3);
        chk("multi_idle_busy", 32'(busy), 32'd0);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: got %0d pending events expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
